// File: rtl/tlc_pkg.sv
// tlc_pkg: state and lamp encodings plus the circular next-approach search.
package tlc_pkg;
  typedef enum logic [1:0] {ALL_RED = 2'd0, GREEN = 2'd1, YELLOW = 2'd2, FLASH = 2'd3} state_t;
  typedef enum logic [1:0] {L_RED, L_YELLOW, L_GREEN, L_OFF} lamp_t;
  localparam int MAX_DIR = 8;
  function automatic logic [2:0] next_dir(input logic [2:0] cur, input logic [MAX_DIR-1:0] dem,
                                          input logic skip_en, input int n);
    int idx;
    next_dir = 3'((int'(cur) + 1) % n);
    // walk from farthest to nearest so the nearest demanding approach wins
    if (skip_en)
      for (int i = n; i >= 1; i--) begin
        idx = (int'(cur) + i) % n;
        if (dem[idx]) next_dir = 3'(idx);
      end
  endfunction
endpackage

// File: rtl/tlc_multiway_if.sv
// tlc_multiway_if: tick, sensors and flash request in; lamps and status out.
interface tlc_multiway_if #(parameter int N_DIR = 2, parameter int DW = $clog2(N_DIR));
  logic tick, flash_req;
  logic [N_DIR-1:0] car_present, red, yellow, green;
  logic [DW-1:0] active_dir;
  logic [1:0] state_o;
  modport master (output tick, car_present, flash_req, input red, yellow, green, active_dir, state_o);
  modport slave (input tick, car_present, flash_req, output red, yellow, green, active_dir, state_o);
endinterface

// File: rtl/tlc_tick_timer.sv
// tlc_tick_timer: down-counter in tick units; load wins over decrement.
module tlc_tick_timer #(
  parameter int TW = 8,
  parameter logic [TW-1:0] RST_VAL = '0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          tick,
  input  logic          load,
  input  logic [TW-1:0] load_val,
  output logic          expired
);
  logic [TW-1:0] cnt;
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt <= RST_VAL;
    else if (load) cnt <= load_val;
    else if (tick) cnt <= cnt - TW'(1);
  assign expired = tick && cnt == '0;
endmodule

// File: rtl/tlc_multiway.sv
// tlc_multiway: N-approach traffic light FSM with demand skipping and flash mode.
module tlc_multiway
  import tlc_pkg::*;
#(
  parameter int N_DIR    = 2,
  parameter int TW       = 8,
  parameter int G_TICKS  = 10,
  parameter int Y_TICKS  = 3,
  parameter int AR_TICKS = 1,
  parameter int SKIP_EN  = 1,
  parameter int DW       = $clog2(N_DIR)
) (
  input logic clk,
  input logic reset,
  tlc_multiway_if.slave bus
);
  state_t state, state_n;
  logic [DW-1:0] dir, dir_n;
  logic phase, phase_n, load, expired;
  logic [TW-1:0] load_val;
  logic [N_DIR-1:0] d, clr, red_n, yellow_n, green_n;
  logic [MAX_DIR-1:0] dem;
  lamp_t code [N_DIR];

  tlc_tick_timer #(.TW(TW), .RST_VAL(TW'(AR_TICKS - 1))) u_timer (
    .clk, .reset, .tick(bus.tick), .load, .load_val, .expired
  );

  assign dem = MAX_DIR'(d | bus.car_present);
  assign bus.active_dir = dir;
  assign bus.state_o = state;

  always_comb begin
    state_n = state;
    dir_n = dir;
    phase_n = phase;
    load = 1'b0;
    load_val = '0;
    case (state)
      ALL_RED: if (expired) begin
        load = 1'b1;
        if (bus.flash_req) begin
          state_n = FLASH;
          phase_n = 1'b1;
        end else begin
          state_n = GREEN;
          dir_n = DW'(next_dir(3'(dir), dem, SKIP_EN != 0, N_DIR));
          load_val = TW'(G_TICKS - 1);
        end
      end
      GREEN: if (expired || (bus.tick && bus.flash_req)) begin
        state_n = YELLOW;
        load = 1'b1;
        load_val = TW'(Y_TICKS - 1);
      end
      YELLOW: if (expired) begin
        state_n = ALL_RED;
        load = 1'b1;
        load_val = TW'(AR_TICKS - 1);
      end
      default: if (bus.tick) begin
        if (bus.flash_req) phase_n = ~phase;
        else begin
          state_n = ALL_RED;
          load = 1'b1;
          load_val = TW'(AR_TICKS - 1);
        end
      end
    endcase
  end

  // lamps are decoded from the next state so they change on the state edge
  for (genvar i = 0; i < N_DIR; i++) begin : g_lamp
    assign code[i] = state_n == FLASH ? (phase_n ? L_YELLOW : L_OFF) :
                     (DW'(i) == dir_n && state_n == GREEN)  ? L_GREEN :
                     (DW'(i) == dir_n && state_n == YELLOW) ? L_YELLOW : L_RED;
    assign red_n[i]    = code[i] == L_RED;
    assign yellow_n[i] = code[i] == L_YELLOW;
    assign green_n[i]  = code[i] == L_GREEN;
    assign clr[i]      = state_n == GREEN && state != GREEN && DW'(i) == dir_n;
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state      <= ALL_RED;
      dir        <= DW'(N_DIR - 1);
      phase      <= 1'b0;
      d          <= '0;
      bus.red    <= '1;
      bus.yellow <= '0;
      bus.green  <= '0;
    end else begin
      state      <= state_n;
      dir        <= dir_n;
      phase      <= phase_n;
      d          <= (d | bus.car_present) & ~clr;
      bus.red    <= red_n;
      bus.yellow <= yellow_n;
      bus.green  <= green_n;
    end
endmodule

// File: tb/tb_tlc_multiway.sv
// tb_tlc_multiway: directed vector table plus corner-case sequences for two configurations.
module tb_tlc_multiway;
  logic clk = 1'b0, reset = 1'b1;
  always #5 clk = ~clk;

  tlc_multiway_if #(.N_DIR(2)) b2 ();
  tlc_multiway_if #(.N_DIR(4)) b4 ();

  tlc_multiway #(.N_DIR(2), .G_TICKS(4), .Y_TICKS(2), .AR_TICKS(1), .SKIP_EN(0)) dut2 (
    .clk(clk), .reset(reset), .bus(b2.slave)
  );
  tlc_multiway #(.N_DIR(4), .G_TICKS(4), .Y_TICKS(2), .AR_TICKS(1), .SKIP_EN(1)) dut4 (
    .clk(clk), .reset(reset), .bus(b4.slave)
  );

  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {logic [1:0] st; logic dir; logic [1:0] r, y, g;} vec_t;
  vec_t tv [16];

  function automatic vec_t mk(input logic [1:0] st, input logic dir, input logic [1:0] r, y, g);
    return '{st, dir, r, y, g};
  endfunction

  always @(negedge clk)
    if (!reset) begin
      assert ((b2.state_o == 2'd3 || $onehot0(~b2.red)) && (b2.green & b2.yellow) == '0)
      else begin
        errors++;
        $display("FAIL safety2 red=%b yellow=%b green=%b", b2.red, b2.yellow, b2.green);
      end
      assert ((b4.state_o == 2'd3 || $onehot0(~b4.red)) && (b4.green & b4.yellow) == '0)
      else begin
        errors++;
        $display("FAIL safety4 red=%b yellow=%b green=%b", b4.red, b4.yellow, b4.green);
      end
    end

  int gcnt, ycnt;

  initial begin
    tv[0] = mk(0, 1, 2'b11, 2'b00, 2'b00);
    for (int k = 1; k <= 4; k++) tv[k] = mk(1, 0, 2'b10, 2'b00, 2'b01);
    for (int k = 5; k <= 6; k++) tv[k] = mk(2, 0, 2'b10, 2'b01, 2'b00);
    tv[7] = mk(0, 0, 2'b11, 2'b00, 2'b00);
    for (int k = 8; k <= 11; k++) tv[k] = mk(1, 1, 2'b01, 2'b00, 2'b10);
    for (int k = 12; k <= 13; k++) tv[k] = mk(2, 1, 2'b01, 2'b10, 2'b00);
    tv[14] = mk(0, 1, 2'b11, 2'b00, 2'b00);
    tv[15] = mk(1, 0, 2'b10, 2'b00, 2'b01);

    b2.tick = 1'b1; b2.flash_req = 1'b0; b2.car_present = '0;
    b4.tick = 1'b1; b4.flash_req = 1'b0; b4.car_present = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_red", 32'(b2.red), 32'h3);
    chk("rst_state", 32'(b2.state_o), 0);
    chk("rst_dir4", 32'(b4.active_dir), 3);
    @(negedge clk);
    reset = 1'b0;

    for (int k = 0; k < 16; k++) begin
      #1;
      chk($sformatf("st[%0d]", k), 32'(b2.state_o), 32'(tv[k].st));
      chk($sformatf("dir[%0d]", k), 32'(b2.active_dir), 32'(tv[k].dir));
      chk($sformatf("red[%0d]", k), 32'(b2.red), 32'(tv[k].r));
      chk($sformatf("yel[%0d]", k), 32'(b2.yellow), 32'(tv[k].y));
      chk($sformatf("grn[%0d]", k), 32'(b2.green), 32'(tv[k].g));
      if (k == 1) begin
        chk("d4_first_dir", 32'(b4.active_dir), 0);
        chk("d4_first_grn", 32'(b4.green), 32'h1);
      end
      if (k == 8) begin
        chk("d4_skip_st", 32'(b4.state_o), 1);
        chk("d4_skip_dir", 32'(b4.active_dir), 3);
        chk("d4_skip_grn", 32'(b4.green), 32'h8);
        chk("d4_latch_clr", 32'(dut4.d), 0);
      end
      if (k == 15) begin
        chk("d4_wrap_dir", 32'(b4.active_dir), 0);
        chk("d4_wrap_grn", 32'(b4.green), 32'h1);
      end
      if (k == 2) b4.car_present = 4'b1000;
      if (k == 4) b4.car_present = 4'b0000;
      @(negedge clk);
    end

    // flash request on the second green cycle, then release it
    #1;
    chk("fl_green2", 32'(b2.state_o), 1);
    b2.flash_req = 1'b1;
    for (int k = 0; k < 9; k++) begin
      logic [1:0] es [9];
      logic [1:0] ey [9];
      logic [1:0] er [9];
      es = '{2'd2, 2'd2, 2'd0, 2'd3, 2'd3, 2'd3, 2'd3, 2'd0, 2'd1};
      ey = '{2'b01, 2'b01, 2'b00, 2'b11, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00};
      er = '{2'b10, 2'b10, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 2'b01};
      @(negedge clk);
      #1;
      chk($sformatf("fl_st[%0d]", k), 32'(b2.state_o), 32'(es[k]));
      chk($sformatf("fl_yel[%0d]", k), 32'(b2.yellow), 32'(ey[k]));
      chk($sformatf("fl_red[%0d]", k), 32'(b2.red), 32'(er[k]));
      if (k == 6) b2.flash_req = 1'b0;
    end
    chk("fl_resume_dir", 32'(b2.active_dir), 1);

    // async reset in the middle of approach 1 yellow
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (12) @(negedge clk);
    #1;
    chk("ar_pre_st", 32'(b2.state_o), 2);
    chk("ar_pre_dir", 32'(b2.active_dir), 1);
    #2;
    reset = 1'b1;
    #1;
    chk("ar_red", 32'(b2.red), 32'h3);
    chk("ar_yel", 32'(b2.yellow), 0);
    chk("ar_grn", 32'(b2.green), 0);
    chk("ar_st", 32'(b2.state_o), 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    #1;
    chk("ar_post_st", 32'(b2.state_o), 1);
    chk("ar_post_dir", 32'(b2.active_dir), 0);
    chk("ar_post_grn", 32'(b2.green), 32'h1);

    // tick strobe every 4th clock stretches each phase by 4x
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    gcnt = 0;
    ycnt = 0;
    for (int k = 0; k < 31; k++) begin
      b2.tick = (k % 4) == 3;
      #1;
      if (b2.state_o == 2'd1 && b2.active_dir == 1'b0) gcnt++;
      if (b2.state_o == 2'd2 && b2.active_dir == 1'b0) ycnt++;
      @(negedge clk);
    end
    b2.tick = 1'b1;
    chk("slow_green_len", 32'(gcnt), 16);
    chk("slow_yel_len", 32'(ycnt), 8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/tlc_multiway.md
Name: tlc_multiway

Overview:
- Parametrised multi-approach traffic light controller: N_DIR approaches, each with its own red/yellow/green lamp outputs.
- Phase durations are counted in external `tick` strobes rather than raw clocks.
- Optional demand-actuated skipping of idle approaches.
- Safe flashing (maintenance) mode.
- Sits between the tick prescaler and the lamp driver.

Parameters:
- N_DIR, 2: number of approaches; legal range 2..8.
- TW, 8: width of the phase timer in bits.
- G_TICKS, 10: green duration in ticks; legal range 1..2^TW-1.
- Y_TICKS, 3: yellow duration in ticks; legal range 1..2^TW-1.
- AR_TICKS, 1: all-red clearance duration in ticks; legal range 1..2^TW-1.
- SKIP_EN, 1: 1 enables demand-based approach skipping; 0 gives a fixed round-robin.
- DW, $clog2(N_DIR): width of active_dir.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high; clock clk.
- tick  in  1  single-cycle timebase strobe; all durations are counted in these.
- car_present  in  N_DIR  per-approach vehicle sensor, level-sensitive.
- flash_req  in  1  request to enter flashing mode; level-sensitive.
- red  out  N_DIR  per-approach red lamp, registered.
- yellow  out  N_DIR  per-approach yellow lamp, registered.
- green  out  N_DIR  per-approach green lamp, registered.
- active_dir  out  DW  index of the approach currently or most recently given right-of-way.
- state_o  out  2  current state encoding.

Behaviour:
- States (2-bit):
  - ALL_RED=0
  - GREEN=1
  - YELLOW=2
  - FLASH=3
- Reset:
  - state=ALL_RED; timer=AR_TICKS-1; active_dir=N_DIR-1, so the first green goes to approach 0.
  - red=all 1s, yellow=0, green=0; demand latches=0; flash phase bit=0.
- Timer:
  - Loaded with DUR-1 on state entry.
  - Decrements only on cycles where tick=1.
  - The state ends on a tick cycle with timer==0.
  - Each state therefore lasts exactly DUR ticks; with tick held at 1, that is DUR clocks.
- Outputs:
  - Lamps are registered and change on the same edge as the state.
  - Exactly one lamp per approach is lit in every non-FLASH state.
  - Only the active_dir approach may be non-red.
  - green and yellow are never both set.
- ALL_RED end:
  - If flash_req=1, go to FLASH.
  - Otherwise go to GREEN of the next approach.
  - Next approach with SKIP_EN=1: first approach, searching circularly from active_dir+1, whose demand latch or car_present is 1. If there is no demand anywhere, use active_dir+1 (modulo N_DIR).
  - Next approach with SKIP_EN=0: always active_dir+1 (modulo N_DIR).
- Demand latches:
  - Latch d[i] is set when car_present[i]=1.
  - d[i] is cleared on the edge where approach i enters GREEN; set and clear on the same edge: clear wins.
- GREEN:
  - Active approach shows green; all others show red.
  - Normal end: go to YELLOW.
  - If flash_req=1 on any tick cycle, end early and go to YELLOW on that tick. The yellow and all-red clearances are never shortened.
- YELLOW:
  - Active approach shows yellow; all others show red.
  - Runs its full duration, then goes to ALL_RED.
- FLASH:
  - red=0, green=0.
  - yellow = all 1s when the flash phase bit is 1, else all 0s. The phase bit toggles on every tick and is 1 on the first cycle of FLASH.
  - Exit: on a tick with flash_req=0, go to ALL_RED for the full AR_TICKS, then resume the normal sequence.
- Boundary conditions:
  - tick and a state end on the same cycle: the transition consumes the tick; the new timer is loaded with no decrement.
  - reset asserted mid-phase: immediate return to the reset values; no clearance is preserved, because all-red is the safe state.
  - active_dir wraps from N_DIR-1 to 0.
  - N_DIR not a power of two: active_dir never exceeds N_DIR-1.

Decomposition:
- Package tlc_pkg holds:
  - the state encoding constants;
  - a lamp-code typedef (RED/YELLOW/GREEN/OFF);
  - the helper function next_dir(cur, demand_vec, skip_en) implementing the circular priority search.
- Sub-module tlc_tick_timer (TW): load value, load strobe, tick input, expired output.
- The FSM, demand latches and lamp decode stay in tlc_multiway.

Test Plan:
- Base configuration for all scenarios: N_DIR=2, G_TICKS=4, Y_TICKS=2, AR_TICKS=1, tick tied to 1.
- Release reset, SKIP_EN=0, flash_req=0:
  - Expect ALL_RED for 1 clk, then approach 0 GREEN for 4 clk, YELLOW for 2, ALL_RED for 1, then approach 1 GREEN.
  - active_dir sequence 1,0,0,...,1.
  - Full period is 14 clk.
- Tick strobe every 4th cycle: approach 0 GREEN lasts exactly 16 clk and YELLOW exactly 8 clk.
- N_DIR=4, SKIP_EN=1, car_present=4'b1000 only:
  - After approach 0 completes, the next GREEN is approach 3; approaches 1 and 2 are skipped.
  - d[3] is clear after approach 3 enters GREEN.
- flash_req raised at the 2nd cycle of GREEN:
  - GREEN ends on that tick; YELLOW 2 clk; ALL_RED 1 clk; then FLASH with yellow=all 1s, all 0s, alternating every clk.
  - Drop flash_req: one further FLASH tick, then ALL_RED 1 clk, then GREEN on the next approach.
- Assert reset during YELLOW of approach 1: on the same cycle (asynchronous), red=all 1s, yellow=0, green=0, state_o=0; after release, approach 0 receives the first green.
- Concurrent check for the whole run: assertion that no two approaches are ever non-red at once, and that green&yellow==0.
